// File: rtl/dma_fsm.sv
// Cache-line DMA sequencer: moves lines from the host FIFO to memory word by word and
// assembles memory words into lines for the host. `DMA_BYTE_ADDR_EN selects byte addressing.
module dma_fsm #(
  parameter int unsigned CL_SIZE_WIDTH = 512,
  parameter int unsigned WORD_SIZE     = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     empty,
  input  logic                     full,
  input  logic                     wr_ready,
  input  logic [CL_SIZE_WIDTH-1:0] dma_rd_data,
  input  logic [WORD_SIZE-1:0]     data_to_host,
  output logic                     host_rd_ready,
  output logic                     host_wr_ready,
  output logic [CL_SIZE_WIDTH-1:0] line_buffer,
  output logic [WORD_SIZE-1:0]     data_to_mem,
  output logic                     DMAEn,
  output logic                     DMAWrEn,
  output logic [31:0]              DMAAddr,
  output logic                     cpu_init
);

  localparam int unsigned NUM_WORDS = CL_SIZE_WIDTH / WORD_SIZE;
  localparam int unsigned K_W       = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(NUM_WORDS - 1);
`ifdef DMA_BYTE_ADDR_EN
  localparam logic [31:0] ADDR_STEP = 32'(WORD_SIZE / 8);
`else
  localparam logic [31:0] ADDR_STEP = 32'd1;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_POP   = 3'd1,
    S_LOAD  = 3'd2,
    S_WRITE = 3'd3,
    S_READ  = 3'd4,
    S_PUSH  = 3'd5
  } state_t;

  state_t                   state, state_nxt;
  logic [K_W-1:0]           k, k_nxt;
  logic [31:0]              wr_addr, wr_addr_nxt;
  logic [31:0]              rd_addr, rd_addr_nxt;
  logic [CL_SIZE_WIDTH-1:0] line_q, line_nxt;
  logic [CL_SIZE_WIDTH-1:0] line_buffer_nxt;
  logic [WORD_SIZE-1:0]     data_to_mem_nxt;
  logic [31:0]              dma_addr_nxt;
  logic                     dma_en_nxt, dma_wr_en_nxt;
  logic                     host_rd_ready_nxt, host_wr_ready_nxt;
  logic                     cpu_init_nxt;

  // State and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      k             <= '0;
      wr_addr       <= '0;
      rd_addr       <= '0;
      line_q        <= '0;
      line_buffer   <= '0;
      data_to_mem   <= '0;
      DMAAddr       <= '0;
      DMAEn         <= 1'b0;
      DMAWrEn       <= 1'b0;
      host_rd_ready <= 1'b0;
      host_wr_ready <= 1'b0;
      cpu_init      <= 1'b0;
    end else begin
      state         <= state_nxt;
      k             <= k_nxt;
      wr_addr       <= wr_addr_nxt;
      rd_addr       <= rd_addr_nxt;
      line_q        <= line_nxt;
      line_buffer   <= line_buffer_nxt;
      data_to_mem   <= data_to_mem_nxt;
      DMAAddr       <= dma_addr_nxt;
      DMAEn         <= dma_en_nxt;
      DMAWrEn       <= dma_wr_en_nxt;
      host_rd_ready <= host_rd_ready_nxt;
      host_wr_ready <= host_wr_ready_nxt;
      cpu_init      <= cpu_init_nxt;
    end
  end

  // Next state; outputs are decoded from the next state so they line up with it
  always_comb begin
    state_nxt       = state;
    k_nxt           = k;
    wr_addr_nxt     = wr_addr;
    rd_addr_nxt     = rd_addr;
    line_nxt        = line_q;
    line_buffer_nxt = line_buffer;
    data_to_mem_nxt = data_to_mem;
    cpu_init_nxt    = cpu_init;

    unique case (state)
      S_IDLE: begin
        k_nxt = '0;
        if (!empty) begin
          state_nxt = S_POP;
        end else if (wr_ready && !full) begin
          state_nxt = S_READ;
        end
      end
      S_POP: begin
        state_nxt = S_LOAD;
      end
      S_LOAD: begin
        line_nxt        = dma_rd_data;
        k_nxt           = '0;
        data_to_mem_nxt = dma_rd_data[WORD_SIZE-1:0];
        state_nxt       = S_WRITE;
      end
      S_WRITE: begin
        wr_addr_nxt = wr_addr + ADDR_STEP;
        k_nxt       = k + K_W'(1);
        if (k == K_LAST) begin
          cpu_init_nxt = 1'b1;
          state_nxt    = S_IDLE;
        end else begin
          // Pre-fetch the next word so it appears together with the next address
          data_to_mem_nxt = line_q[WORD_SIZE*k_nxt +: WORD_SIZE];
        end
      end
      S_READ: begin
        line_buffer_nxt[WORD_SIZE*k +: WORD_SIZE] = data_to_host;
        rd_addr_nxt = rd_addr + ADDR_STEP;
        k_nxt       = k + K_W'(1);
        if (k == K_LAST) begin
          state_nxt = S_PUSH;
        end
      end
      S_PUSH: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    dma_en_nxt        = (state_nxt == S_WRITE) || (state_nxt == S_READ);
    dma_wr_en_nxt     = (state_nxt == S_WRITE);
    host_rd_ready_nxt = (state_nxt == S_POP);
    host_wr_ready_nxt = (state_nxt == S_PUSH);

    if (state_nxt == S_WRITE) begin
      dma_addr_nxt = wr_addr_nxt;
    end else if (state_nxt == S_READ) begin
      dma_addr_nxt = rd_addr_nxt;
    end else begin
      dma_addr_nxt = DMAAddr;
    end
  end

endmodule

// File: tb/tb_dma_fsm.sv
// Scoreboard bench for dma_fsm: stimulus queues expected DMA/handshake events,
// a negedge monitor pops and checks them as the DUT presents them.
module tb_dma_fsm;

  localparam int unsigned CL = 512;
  localparam int unsigned W  = 32;
  localparam int unsigned NW = 16;
`ifdef DMA_BYTE_ADDR_EN
  localparam logic [31:0] STEP = 32'd4;
`else
  localparam logic [31:0] STEP = 32'd1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          empty = 1'b1;
  logic          full = 1'b0;
  logic          wr_ready = 1'b0;
  logic [CL-1:0] dma_rd_data = '0;
  logic [W-1:0]  data_to_host = '0;
  logic          host_rd_ready, host_wr_ready;
  logic [CL-1:0] line_buffer;
  logic [W-1:0]  data_to_mem;
  logic          DMAEn, DMAWrEn;
  logic [31:0]   DMAAddr;
  logic          cpu_init;

  dma_fsm #(.CL_SIZE_WIDTH(CL), .WORD_SIZE(W)) dut (
    .clk(clk), .rst_n(rst_n), .empty(empty), .full(full), .wr_ready(wr_ready),
    .dma_rd_data(dma_rd_data), .data_to_host(data_to_host),
    .host_rd_ready(host_rd_ready), .host_wr_ready(host_wr_ready),
    .line_buffer(line_buffer), .data_to_mem(data_to_mem),
    .DMAEn(DMAEn), .DMAWrEn(DMAWrEn), .DMAAddr(DMAAddr), .cpu_init(cpu_init)
  );

  always #5 clk = ~clk;

  typedef enum int {EV_NONE, EV_POP, EV_WR, EV_RD, EV_PUSH} ev_t;
  typedef struct {
    ev_t           kind;
    logic [CL-1:0] line;
    logic [31:0]   data;
    logic [31:0]   addr;
  } exp_t;

  exp_t        sbq[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_wr_addr = '0;
  logic [31:0] exp_rd_addr = '0;
  int          cyc = 0;
  int          last_rd_cyc = -10;
  int          rd_idx = 0;

  task automatic check(input string name, input logic [CL-1:0] got, input logic [CL-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference line: word k = 15-k (word 0 least significant)
  function automatic logic [CL-1:0] ref_line();
    logic [CL-1:0] l;
    for (int i = 0; i < NW; i++) l[W*i +: W] = W'(NW - 1 - i);
    return l;
  endfunction

  task automatic exp_write(input int nbeats);
    exp_t e;
    e = '{kind: EV_POP, line: '0, data: '0, addr: '0};
    sbq.push_back(e);
    for (int i = 0; i < nbeats; i++) begin
      e = '{kind: EV_WR, line: '0, data: 32'(NW - 1 - i), addr: exp_wr_addr};
      sbq.push_back(e);
      exp_wr_addr = exp_wr_addr + STEP;
    end
  endtask

  task automatic exp_read();
    exp_t e;
    for (int i = 0; i < NW; i++) begin
      e = '{kind: EV_RD, line: '0, data: '0, addr: exp_rd_addr};
      sbq.push_back(e);
      exp_rd_addr = exp_rd_addr + STEP;
    end
    e = '{kind: EV_PUSH, line: ref_line(), data: '0, addr: '0};
    sbq.push_back(e);
  endtask

  // Memory responder: returns 15..0 on successive read beats
  always @(negedge clk) begin
    if (rst_n && DMAEn && !DMAWrEn) begin
      data_to_host = W'(NW - 1 - rd_idx);
      rd_idx = (rd_idx + 1) % NW;
    end
  end

  // Monitor: every presented event must match the head of the scoreboard
  always @(negedge clk) begin
    ev_t  ev;
    exp_t e;
    cyc++;
    ev = EV_NONE;
    if (rst_n) begin
      if (host_rd_ready)         ev = EV_POP;
      else if (DMAEn && DMAWrEn) ev = EV_WR;
      else if (DMAEn)            ev = EV_RD;
      else if (host_wr_ready)    ev = EV_PUSH;
    end
    if (ev != EV_NONE) begin
      if (sbq.size() == 0) begin
        check("unexpected_event", CL'(ev), CL'(EV_NONE));
      end else begin
        e = sbq.pop_front();
        check("event_kind", CL'(ev), CL'(e.kind));
        case (e.kind)
          EV_WR: begin
            check("wr_data", CL'(data_to_mem), CL'(e.data));
            check("wr_addr", CL'(DMAAddr), CL'(e.addr));
          end
          EV_RD: begin
            check("rd_addr", CL'(DMAAddr), CL'(e.addr));
            last_rd_cyc = cyc;
          end
          EV_PUSH: begin
            check("push_line", line_buffer, e.line);
            check("push_timing", CL'(cyc), CL'(last_rd_cyc + 1));
          end
          default: ;
        endcase
      end
    end
  end

  task automatic wait_pop();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!host_rd_ready && n < 50);
    check("pop_seen", CL'(host_rd_ready), CL'(1));
  endtask

  task automatic wait_rd_start();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(DMAEn && !DMAWrEn) && n < 100);
    check("read_start_seen", CL'(DMAEn && !DMAWrEn), CL'(1));
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sbq.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", CL'(sbq.size()), CL'(0));
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int cnt;
    int n;
    dma_rd_data = ref_line();

    // Reset values
    #1;
    check("rst_dmaen", CL'(DMAEn), CL'(0));
    check("rst_dmawren", CL'(DMAWrEn), CL'(0));
    check("rst_cpu_init", CL'(cpu_init), CL'(0));
    check("rst_line_buffer", line_buffer, '0);
    check("rst_data_to_mem", CL'(data_to_mem), CL'(0));
    check("rst_dmaaddr", CL'(DMAAddr), CL'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle with nothing to do
    repeat (20) @(negedge clk);
    check("idle_dmaen", CL'(DMAEn), CL'(0));
    check("idle_strobes", CL'({host_rd_ready, host_wr_ready}), CL'(0));

    // Write path
    exp_write(NW);
    empty = 1'b0;
    wait_pop();
    empty = 1'b1;
    wait_drain();
    check("cpu_init_after_write", CL'(cpu_init), CL'(1));

    // Read path
    exp_read();
    wr_ready = 1'b1;
    wait_rd_start();
    wr_ready = 1'b0;
    wait_drain();

    // Stall on full, release starts read next cycle
    full = 1'b1;
    wr_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("stall_no_read", CL'(DMAEn), CL'(0));
    exp_read();
    full = 1'b0;
    @(negedge clk);
    check("stall_release_read", CL'({DMAEn, DMAWrEn}), CL'(2'b10));
    wr_ready = 1'b0;
    wait_drain();

    // Priority: write before read when both requested
    exp_write(NW);
    exp_read();
    empty = 1'b0;
    wr_ready = 1'b1;
    wait_pop();
    empty = 1'b1;
    wait_rd_start();
    wr_ready = 1'b0;
    wait_drain();

    // Abort during write word 7
    exp_write(8);
    empty = 1'b0;
    wait_pop();
    empty = 1'b1;
    cnt = 0;
    n = 0;
    while (cnt < 8 && n < 100) begin
      @(negedge clk);
      n++;
      if (DMAEn && DMAWrEn) cnt++;
    end
    #2 rst_n = 1'b0;
    #1;
    check("abort_dmaen", CL'(DMAEn), CL'(0));
    check("abort_dmawren", CL'(DMAWrEn), CL'(0));
    check("abort_dmaaddr", CL'(DMAAddr), CL'(0));
    check("abort_cpu_init", CL'(cpu_init), CL'(0));
    check("abort_beats_seen", CL'(sbq.size()), CL'(0));
    exp_wr_addr = '0;
    exp_rd_addr = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Fresh write after abort starts again at address 0
    exp_write(NW);
    empty = 1'b0;
    wait_pop();
    empty = 1'b1;
    wait_drain();
    check("cpu_init_after_rewrite", CL'(cpu_init), CL'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
